// File: rtl/hilo_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit: MIPS funct codes
// handled by the unit, the FSM state encoding and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package hilo_muldiv_pkg;

  // Funct codes; identical to the values the ALU decoder sees in EX.
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Multi-cycle ops (everything except MTHI/MTLO).
  function automatic logic is_arith(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_if
// Request/result bundle between the EX stage (master) and the multiply/divide
// unit (slave).
//   start, ctl, a, b          : request (master -> slave)
//   busy, done, div_by_zero   : status  (slave -> master)
//   hi, lo                    : HI/LO register contents (slave -> master)
// -----------------------------------------------------------------------------
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ctl, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, ctl, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
//   op_is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i/acc_o : 2W multiply accumulator {partial product, remaining multiplier}
//   rem_i/rem_o : W+1 bit partial remainder
//   quo_i/quo_o : dividend bits shifting out / quotient bits shifting in
//   opnd_i      : multiplicand (multiply) or divisor (divide), magnitudes
// Fields not used by the selected operation pass through unchanged.
// -----------------------------------------------------------------------------
module muldiv_step
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op_is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH:0]     rem_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH:0]     rem_o,
  output logic [WIDTH-1:0]   quo_o
);

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set; the carry lands in the top bit before the shift.
  logic [WIDTH:0]   sum;
  // Divide: the trial value is one bit wider than the remainder so the
  // subtract's MSB is a pure borrow flag.
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
  assign trial  = {rem_i, quo_i[WIDTH-1]};
  assign diff   = trial - {2'b00, opnd_i};
  assign borrow = diff[WIDTH+1];

  always_comb begin
    acc_o = acc_i;
    rem_o = rem_i;
    quo_o = quo_i;
    if (op_is_div_i) begin
      rem_o = borrow ? trial[WIDTH:0] : diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], ~borrow};
    end else if (acc_i[0]) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// -----------------------------------------------------------------------------
// hilo_muldiv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO register pair.
// Executes MULT/MULTU/DIV/DIVU over WIDTH radix-2 steps plus one sign-fix
// cycle, and MTHI/MTLO in a single cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any operation in flight)
//   bus   : slave side of hilo_muldiv_if (start/ctl/a/b in,
//           busy/done/div_by_zero/hi/lo out)
// -----------------------------------------------------------------------------
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  hilo_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int W2    = 2 * WIDTH;

  // Control state
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             op_div_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             b_zero_q;

  // Iteration datapath
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opnd_q;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] u;
    u = v;
    if (is_signed && v[WIDTH-1]) magnitude = ~u + WIDTH'(1);
    else                         magnitude = u;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  // Request decode (only meaningful in IDLE)
  logic             take_arith;
  logic             start_div;
  logic             start_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign start_div    = is_div_op(bus.ctl);
  assign start_signed = is_signed_op(bus.ctl);
  assign take_arith   = (state_q == IDLE) && bus.start && is_arith(bus.ctl);
  assign mag_a        = magnitude(bus.a, start_signed);
  assign mag_b        = magnitude(bus.b, start_signed);

  // Sign correction applied in FIX. Sign flags are zero for unsigned ops, so
  // these reduce to pass-through there. Signed overflow (MIN / -1) needs no
  // special case: the magnitude quotient 2^(W-1) negates to itself.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign prod_fix = (sign_a_q ^ sign_b_q) ? neg_2w(acc_q) : acc_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? neg_w(quo_q)  : quo_q;
  assign rem_fix  = sign_a_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_is_div_i (op_div_q),
    .acc_i       (acc_q),
    .rem_i       (rem_q),
    .quo_i       (quo_q),
    .opnd_i      (opnd_q),
    .acc_o       (acc_d),
    .rem_o       (rem_d),
    .quo_o       (quo_d)
  );

  // Iteration registers carry no reset: they are always loaded on acceptance
  // and only reach hi/lo through the FIX cycle.
  always_ff @(posedge clk) begin
    if (take_arith) begin
      opnd_q <= start_div ? mag_b : mag_a;
      acc_q  <= {{WIDTH{1'b0}}, mag_b};
      rem_q  <= '0;
      quo_q  <= mag_a;
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.ctl == F_MTHI) begin
              hi_q   <= bus.a;
              done_q <= 1'b1;
            end else if (bus.ctl == F_MTLO) begin
              lo_q   <= bus.a;
              done_q <= 1'b1;
            end else if (is_arith(bus.ctl)) begin
              state_q  <= RUN;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              op_div_q <= start_div;
              sign_a_q <= start_signed & bus.a[WIDTH-1];
              sign_b_q <= start_signed & bus.b[WIDTH-1];
              b_zero_q <= start_div && (bus.b == '0);
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (op_div_q) begin
            // With a zero divisor every trial succeeds, so the remainder
            // already equals the dividend; only the quotient is forced.
            hi_q  <= rem_fix;
            lo_q  <= b_zero_q ? {WIDTH{1'b1}} : quo_fix;
            dbz_q <= b_zero_q;
          end else begin
            hi_q <= prod_fix[W2-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
